// File: rtl/lfsr_stream_gen.sv
// Galois LFSR word generator with a valid/ready output stream,
// multi-step advance, runtime reseed, lock-up guard and wrap tracking.
module lfsr_stream_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h91,
    parameter int               STEPS = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Serial_Out,
    output logic [WIDTH-1:0] Step_Count,
    output logic             Wrap,
    output logic             Lockup
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_stream_gen: WIDTH must be 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_stream_gen: SEED must be non-zero");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_stream_gen: STEPS must be 1..WIDTH");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] adv;
    logic             accept;

    // One Galois shift; bit 0 of the tap mask is never used.
    function automatic logic [WIDTH-1:0] lfsr_step(
        input logic [WIDTH-1:0] y
    );
        logic             fb;
        logic [WIDTH-1:0] mask;
        fb   = y[WIDTH-1];
        mask = {TAPS[WIDTH-1:1], 1'b0} & {WIDTH{fb}};
        return {y[WIDTH-2:0], fb} ^ mask;
    endfunction

    // Unrolled STEPS-fold advance of the current state.
    always_comb begin
        adv = y_q;
        for (int i = 0; i < STEPS; i++) begin
            adv = lfsr_step(adv);
        end
    end

    // Next-state logic: Load beats everything, accept advances the word.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        accept   = (state_q == ST_RUN) && Out_Ready;
        if (Load) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            if (Load_Value == '0) begin
                y_d      = SEED;
                start_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                y_d     = Load_Value;
                start_d = Load_Value;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Enable) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        y_d = adv;
                        if (adv == start_q) begin
                            wrap_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                        if (!Enable) state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d = Enable ? ST_RUN : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            y_q      <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign Out_Data   = y_q;
    assign Out_Valid  = (state_q == ST_RUN);
    assign Serial_Out = y_q[WIDTH-1];
    assign Step_Count = cnt_q;
    assign Wrap       = wrap_q;
    assign Lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: directed scenarios plus random traffic
// checked cycle by cycle against an arithmetic reference model.
module tb_lfsr_stream_gen;

    localparam int TAPS_I = 'h1D;
    localparam int SEED_I = 'h91;

    logic       clk;
    logic       rst;
    logic       en, load, rdy;
    logic [7:0] lv;
    logic [7:0] d;
    logic       v, ser, wrap, lock;
    logic [7:0] cnt;

    logic       en2, rdy2;
    logic [7:0] d2, cnt2;
    logic       v2, ser2, wrap2, lock2;

    int checks   = 0;
    int failures = 0;

    // model of the default instance
    int m_st;
    int m_y, m_start, m_cnt, m_acc;
    int m_wrap, m_lock;

    lfsr_stream_gen u_dut (
        .Clock(clk), .Reset(rst), .Enable(en), .Load(load),
        .Load_Value(lv), .Out_Data(d), .Out_Valid(v),
        .Out_Ready(rdy), .Serial_Out(ser), .Step_Count(cnt),
        .Wrap(wrap), .Lockup(lock)
    );

    lfsr_stream_gen #(.STEPS(8)) u_dut8 (
        .Clock(clk), .Reset(rst), .Enable(en2), .Load(1'b0),
        .Load_Value(8'h00), .Out_Data(d2), .Out_Valid(v2),
        .Out_Ready(rdy2), .Serial_Out(ser2), .Step_Count(cnt2),
        .Wrap(wrap2), .Lockup(lock2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n shifts of the spec's Galois rule, using plain integer arithmetic
    function automatic int ref_adv(input int y, input int n);
        int x;
        x = y;
        for (int i = 0; i < n; i++) begin
            if (x >= 128) x = ((x * 2) % 256) ^ ((TAPS_I & 'hFE) | 1);
            else          x = (x * 2) % 256;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, update the model from the driven inputs, compare
    task automatic tick();
        @(posedge clk);
        m_wrap = 0;
        m_lock = 0;
        if (!rst) begin
            m_st = 0; m_y = SEED_I; m_start = SEED_I;
            m_cnt = 0; m_acc = 0;
        end else if (load) begin
            m_st = 2;
            if (lv == 8'h00) begin
                m_y = SEED_I; m_lock = 1;
            end else begin
                m_y = int'(lv);
            end
            m_start = m_y; m_cnt = 0; m_acc = 0;
        end else if (m_st == 0) begin
            if (en) m_st = 1;
        end else if (m_st == 2) begin
            m_st = en ? 1 : 0;
        end else if (rdy) begin
            m_y = ref_adv(m_y, 1);
            m_acc++;
            if (m_y == m_start) begin
                m_wrap = 1; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
            if (!en) m_st = 0;
        end
        #1;
        chk("valid", 32'(v), 32'(m_st == 1));
        chk("data", 32'(d), 32'(m_y));
        chk("count", 32'(cnt), 32'(m_cnt));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("lockup", 32'(lock), 32'(m_lock));
        chk("serial", 32'(ser), 32'((m_y >> 7) & 1));
    endtask

    initial begin
        logic [7:0] t1 [5];
        logic [7:0] sd, sc;
        bit seen;
        bit acc2;
        int k;

        t1[0] = 8'h91; t1[1] = 8'h3F; t1[2] = 8'h7E;
        t1[3] = 8'hFC; t1[4] = 8'hE5;

        rst = 1'b0; en = 1'b0; load = 1'b0; rdy = 1'b0; lv = 8'h00;
        en2 = 1'b0; rdy2 = 1'b0;
        m_st = 0; m_y = SEED_I; m_start = SEED_I;
        m_cnt = 0; m_acc = 0; m_wrap = 0; m_lock = 0;

        // reset state
        tick();
        tick();
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_data", 32'(d), 32'h91);
        chk("rst_count", 32'(cnt), 32'd0);
        rst = 1'b1;
        tick();

        // T1: enable -> valid one cycle later, fixed sequence
        en = 1'b1; rdy = 1'b1;
        tick();
        chk("t1_valid_rise", 32'(v), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t1_seq", 32'(d), 32'(t1[i]));
            if (i < 4) tick();
        end

        // T2: stall for 5 cycles, then resume without loss
        rdy = 1'b0;
        sd = d; sc = cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_data", 32'(d), 32'(sd));
            chk("t2_hold_count", 32'(cnt), 32'(sc));
            chk("t2_hold_valid", 32'(v), 32'd1);
        end
        rdy = 1'b1;
        tick();
        chk("t2_resume", 32'(d), 32'(ref_adv(int'(sd), 1)));
        chk("t2_resume_cnt", 32'(cnt), 32'(sc) + 32'd1);

        // T3: continuous accept until wrap
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (wrap) seen = 1'b1;
        end
        chk("t3_wrap_seen", 32'(seen), 32'd1);
        chk("t3_accepts", 32'(m_acc), 32'd255);
        chk("t3_data", 32'(d), 32'h91);
        chk("t3_count", 32'(cnt), 32'd0);

        // T4: zero seed -> lockup, then a mid-run reseed
        load = 1'b1; lv = 8'h00;
        tick();
        chk("t4_lockup", 32'(lock), 32'd1);
        chk("t4_lock_data", 32'(d), 32'h91);
        load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        load = 1'b1; lv = 8'hA5;
        tick();
        chk("t4_load_valid", 32'(v), 32'd0);
        chk("t4_load_data", 32'(d), 32'hA5);
        chk("t4_load_count", 32'(cnt), 32'd0);
        load = 1'b0;
        tick();
        chk("t4_run_valid", 32'(v), 32'd1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            rdy  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 19) == 0);
            lv   = ($urandom_range(0, 3) == 0) ? 8'h00
                                               : 8'($urandom_range(0, 255));
            tick();
        end
        load = 1'b0; en = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // T5: STEPS=8 instance yields every 8th word
        en2 = 1'b1;
        tick();
        chk("t5_valid", 32'(v2), 32'd1);
        chk("t5_first", 32'(d2), 32'h91);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            rdy2 = 1'($urandom_range(0, 1));
            acc2 = v2 && rdy2;
            tick();
            if (acc2) k++;
            chk("t5_data", 32'(d2), 32'(ref_adv(SEED_I, 8 * k)));
            chk("t5_count", 32'(cnt2), 32'(k));
        end
        en2 = 1'b0;

        // T6: reset in the middle of an accept
        en = 1'b1; rdy = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_valid", 32'(v), 32'd0);
        chk("t6_data", 32'(d), 32'h91);
        chk("t6_count", 32'(cnt), 32'd0);
        rst = 1'b1; en = 1'b0;
        tick();
        chk("t6_idle", 32'(v), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
